// File: rtl/dcache_ctrl.sv
// dcache_ctrl: direct-mapped, write-through, no-write-allocate data cache controller.
module dcache_ctrl #(
  parameter int DATA_WIDTH = 32,
  parameter int SET_SIZE   = 10
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cpu_req,
  input  logic                  cpu_we,
  input  logic [DATA_WIDTH-1:0] cpu_addr,
  input  logic [DATA_WIDTH-1:0] cpu_wdata,
  input  logic [1:0]            cpu_byte_sel,
  output logic [DATA_WIDTH-1:0] cpu_rdata,
  output logic                  cpu_stall,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [DATA_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic [1:0]            mem_byte_sel,
  input  logic                  mem_ack,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);
  localparam int TW   = DATA_WIDTH - SET_SIZE - 2;
  localparam int SETS = 1 << SET_SIZE;
  typedef enum logic [1:0] {IDLE, REFILL, WRITE, DONE} state_t;
  state_t state;
  logic [SETS-1:0] valid;
  logic [DATA_WIDTH-1:0] data_mem [SETS];
  logic [TW-1:0] tag_mem [SETS];
  logic [SET_SIZE-1:0] idx;
  logic [TW-1:0] tag;
  logic hit, hit_q;
  logic [3:0] be, be_q;
  logic [DATA_WIDTH-1:0] wpos, mask, merged;
  assign idx = cpu_addr[SET_SIZE+1:2];
  assign tag = cpu_addr[DATA_WIDTH-1:SET_SIZE+2];
  assign hit = valid[idx] && (tag_mem[idx] == tag);
  assign cpu_stall = (state == REFILL) || (state == WRITE) ||
                     (state == IDLE && cpu_req && (cpu_we || !hit));
  assign cpu_rdata = (state == IDLE && cpu_req && !cpu_we && hit) ? data_mem[idx] : '0;
  always_comb begin
    be   = cpu_byte_sel == 2'b10 ? 4'b0001 << cpu_addr[1:0] :
           cpu_byte_sel == 2'b01 ? (cpu_addr[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    wpos = cpu_byte_sel == 2'b10 ? {{(DATA_WIDTH-8){1'b0}}, cpu_wdata[7:0]} << {cpu_addr[1:0], 3'b000} :
           cpu_byte_sel == 2'b01 ? {{(DATA_WIDTH-16){1'b0}}, cpu_wdata[15:0]} << {cpu_addr[1], 4'b0000} :
           cpu_wdata;
    mask = '0;
    for (int i = 0; i < 4; i++) mask[i*8 +: 8] = {8{be_q[i]}};
    merged = (data_mem[idx] & ~mask) | (mem_wdata & mask);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      valid        <= '0;
      mem_req      <= 1'b0;
      mem_we       <= 1'b0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      mem_byte_sel <= '0;
      hit_q        <= 1'b0;
      be_q         <= '0;
    end else begin
      case (state)
        IDLE: if (cpu_req && cpu_we) begin
          state        <= WRITE;
          mem_req      <= 1'b1;
          mem_we       <= 1'b1;
          mem_addr     <= {cpu_addr[DATA_WIDTH-1:2], 2'b00};
          mem_wdata    <= wpos;
          mem_byte_sel <= cpu_byte_sel;
          hit_q        <= hit;
          be_q         <= be;
        end else if (cpu_req && !hit) begin
          state    <= REFILL;
          mem_req  <= 1'b1;
          mem_we   <= 1'b0;
          mem_addr <= {cpu_addr[DATA_WIDTH-1:2], 2'b00};
        end
        REFILL: if (mem_ack) begin
          state      <= IDLE;
          mem_req    <= 1'b0;
          valid[idx] <= 1'b1;
        end
        WRITE: if (mem_ack) begin
          state   <= DONE;
          mem_req <= 1'b0;
          mem_we  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
  // Data/tag storage needs no reset; only the valid bits gate a hit.
  always_ff @(posedge clk) begin
    if (state == REFILL && mem_ack) begin
      data_mem[idx] <= mem_rdata;
      tag_mem[idx]  <= tag;
    end else if (state == WRITE && mem_ack && hit_q) begin
      data_mem[idx] <= merged;
    end
  end
endmodule
